// File: rtl/load_use_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : load_use_hazard_ctrl
// Purpose  : Load-use hazard controller for loads whose data becomes
//            forwardable LOAD_LAT cycles after EX. A shift tracker remembers
//            the destinations of recent loads; an IF/ID instruction that reads
//            one of them is held back until the data is forwardable. Also
//            handles register-0 exemption, per-operand use qualifiers,
//            taken-branch flush, memory-busy freeze and a saturating stall
//            counter.
// Ports    : clk, rst_n                  - clock, async active-low reset
//            IDEXMemRead, IDEXRt         - load in ID/EX and its destination
//            IFIDRs/Rt, IFIDUseRs/Rt     - IF/ID sources and use qualifiers
//            branchTaken, memBusy        - flush / global hold requests
//            cntClr                      - synchronous clear of stallCount
//            PCWrite, IFIDWrite          - PC and IF/ID write enables
//            ctrlSetZero, IFIDFlush      - bubble insert, IF/ID flush
//            pipeFreeze                  - hold every pipeline register
//            stallCount                  - saturating load-use stall count
// Revision : 1.0 - initial release
// ============================================================================
module load_use_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              IDEXMemRead,
  input  logic [REG_AW-1:0] IDEXRt,
  input  logic [REG_AW-1:0] IFIDRs,
  input  logic [REG_AW-1:0] IFIDRt,
  input  logic              IFIDUseRs,
  input  logic              IFIDUseRt,
  input  logic              branchTaken,
  input  logic              memBusy,
  input  logic              cntClr,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              ctrlSetZero,
  output logic              IFIDFlush,
  output logic              pipeFreeze,
  output logic [CNT_W-1:0]  stallCount
);

  // Entry i holds the load that left EX i+1 cycles ago.
  logic [LOAD_LAT-1:0] r_vld;
  logic [REG_AW-1:0]   r_dst [LOAD_LAT];
  logic [CNT_W-1:0]    r_cnt;

  logic w_hit_rs;
  logic w_hit_rt;
  logic w_hz;
  logic w_cnt_inc;
  logic w_unused;

  // Tracker: shifts on every non-frozen cycle, including stall cycles, so
  // the load ages even while the dependent instruction waits in IF/ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LOAD_LAT; i++) r_dst[i] <= '0;
    end else if (!memBusy) begin
      r_vld[0] <= IDEXMemRead && (IDEXRt != '0);
      r_dst[0] <= IDEXRt;
      for (int i = 1; i < LOAD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_dst[i] <= r_dst[i-1];
      end
    end
  end

  // The oldest entry has reached forwardability and is never compared;
  // it is kept so the tracker depth matches the load latency.
  assign w_unused = ^{r_vld[LOAD_LAT-1], r_dst[LOAD_LAT-1]};

  // Source matching: the load in ID/EX plus entries 0..LOAD_LAT-2.
  always_comb begin
    w_hit_rs = IDEXMemRead && (IDEXRt == IFIDRs);
    w_hit_rt = IDEXMemRead && (IDEXRt == IFIDRt);
    for (int i = 0; i < LOAD_LAT - 1; i++) begin
      if (r_vld[i] && (r_dst[i] == IFIDRs)) w_hit_rs = 1'b1;
      if (r_vld[i] && (r_dst[i] == IFIDRt)) w_hit_rt = 1'b1;
    end
  end

  assign w_hz = (IFIDUseRs && (IFIDRs != '0) && w_hit_rs) ||
                (IFIDUseRt && (IFIDRt != '0) && w_hit_rt);

  // A stall is only counted when it actually takes effect (not frozen,
  // not overridden by a branch flush).
  assign w_cnt_inc = !memBusy && !branchTaken && w_hz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cntClr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign stallCount = r_cnt;

  // Output decode in priority order; reset forces the free-running pattern.
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    ctrlSetZero = 1'b0;
    IFIDFlush   = 1'b0;
    pipeFreeze  = 1'b0;
    if (rst_n) begin
      if (memBusy) begin
        pipeFreeze = 1'b1;
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
      end else if (branchTaken) begin
        IFIDFlush   = 1'b1;
        ctrlSetZero = 1'b1;
      end else if (w_hz) begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        ctrlSetZero = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/load_use_hazard_ctrl.md
Name: load_use_hazard_ctrl

Overview:
Parametrised successor to the single-cycle load-use stall detector. It covers loads whose data returns LOAD_LAT cycles after EX, using an internal shift tracker of in-flight load destinations. It adds register-0 exemption, per-operand use qualifiers, taken-branch flush, memory-busy freeze and a saturating stall counter. It sits beside the IF/ID and ID/EX pipeline registers and drives PC, IF/ID and control-zero enables.

Parameters:
REG_AW, 5, register address width
LOAD_LAT, 2, cycles after EX until load data is forwardable; legal range 1..4 (1 = classic one-bubble load-use)
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
IDEXMemRead  input  1  instruction in ID/EX is a load
IDEXRt  input  REG_AW  load destination in ID/EX
IFIDRs  input  REG_AW  source rs of instruction in IF/ID
IFIDRt  input  REG_AW  source rt of instruction in IF/ID
IFIDUseRs  input  1  IF/ID instruction reads rs
IFIDUseRt  input  1  IF/ID instruction reads rt
branchTaken  input  1  branch resolved taken this cycle
memBusy  input  1  data memory not ready; whole pipeline must hold
cntClr  input  1  synchronous clear of stallCount
PCWrite  output  1  PC update enable
IFIDWrite  output  1  IF/ID register write enable
ctrlSetZero  output  1  zero ID control signals (insert bubble into ID/EX)
IFIDFlush  output  1  clear IF/ID to NOP
pipeFreeze  output  1  hold every pipeline register
stallCount  output  CNT_W  count of load-use stall cycles

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Tracker: LOAD_LAT entries {valid, dst}.
  - Entry i holds the load that left EX i+1 cycles ago.
  - The tracker advances on every cycle with memBusy=0.
  - Advance rule: entry0 <= {IDEXMemRead && IDEXRt!=0, IDEXRt}; entry i <= entry i-1.
  - With memBusy=1 the tracker holds.
- Match: m(r) = (r!=0) and (r equals IDEXRt with IDEXMemRead=1, or r equals dst of any valid entry i with i <= LOAD_LAT-2).
- Hazard: hz = (IFIDUseRs && m(IFIDRs)) || (IFIDUseRt && m(IFIDRt)).
- Register 0 never causes a stall.
- Outputs are combinational from inputs and tracker state, evaluated in strict priority order:
  1. memBusy=1: pipeFreeze=1, PCWrite=0, IFIDWrite=0, ctrlSetZero=0, IFIDFlush=0; counter holds.
  2. else branchTaken=1: IFIDFlush=1, ctrlSetZero=1, PCWrite=1, IFIDWrite=1, pipeFreeze=0. Branch wins over hz; no stall is counted.
  3. else hz=1: PCWrite=0, IFIDWrite=0, ctrlSetZero=1, IFIDFlush=0, pipeFreeze=0; stallCount increments.
  4. else: PCWrite=1, IFIDWrite=1, all others 0.
- Stall count:
  - A load followed immediately by a dependent instruction stalls exactly LOAD_LAT cycles.
  - A dependent instruction at distance d stalls max(0, LOAD_LAT-d+1) cycles.
- Counter:
  - Saturates at all-ones.
  - cntClr=1 forces 0 on the next edge and has priority over increment.
- Reset (rst_n=0, asynchronous):
  - Tracker valids=0, stallCount=0.
  - Outputs are forced to PCWrite=1, IFIDWrite=1, ctrlSetZero=0, IFIDFlush=0, pipeFreeze=0 regardless of inputs.
  - Reset asserted mid-stall drops all pending hazards.
  - The first cycle after release sees an empty tracker.
- LOAD_LAT=1: no tracker entries are checked; behaviour equals the classic detector plus r0, use-qualifier, branch and freeze handling.

Test Plan:
- LOAD_LAT=2; lw $8 in ID/EX, add rs=$8 (UseRs=1) in IF/ID → PCWrite=0, IFIDWrite=0, ctrlSetZero=1 for exactly 2 cycles, then 1/1/0; stallCount=2.
- LOAD_LAT=2; lw $8, unrelated instr, add rs=$8 → 1 stall cycle; stallCount=1. Same with LOAD_LAT=1 → 0 stalls.
- lw $0 followed by add rs=$0; separately, lw $9 followed by instr with IFIDRt=9 and UseRt=0 → no stall in either case, PCWrite=1.
- Load hazard cycle with memBusy=1 held 3 cycles → pipeFreeze=1, ctrlSetZero=0 and stallCount unchanged during freeze; the full 2-cycle stall then occurs after memBusy drops.
- Hazard present with branchTaken=1 → IFIDFlush=1, ctrlSetZero=1, PCWrite=1, counter unchanged.
- Pulse rst_n low during the second stall cycle → outputs immediately 1/1/0/0/0, stallCount=0, no stall after release. Drive 2^CNT_W+5 stall cycles → stallCount saturates at all-ones; cntClr → 0.
